// File: rtl/countdown_ctrl.sv
// Sequencing controller for the mm:ss countdown timer: owns the seconds-remaining
// register, the tick prescaler and the SET/PAUSE/RUN/EXPIRED state machine.
module countdown_ctrl #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        start_pause,
    input  logic        min_plus,
    input  logic        sec_plus,
    output logic [11:0] value,
    output logic [15:0] bcd,
    output logic        running,
    output logic        stop,
    output logic        alarm
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    localparam logic [1:0] ST_SET     = 2'd0;
    localparam logic [1:0] ST_PAUSE   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [11:0]   value_reg, value_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [AW-1:0] alarm_cnt_reg, alarm_cnt_next;
    logic          alarm_reg, alarm_next;
    logic          running_reg;
    logic          stop_reg;

    logic          timed;
    logic          tick;
    logic [12:0]   sum_raw;
    logic [11:0]   value_add;
    logic [11:0]   value_dec;

    assign timed = (state_reg == ST_RUN) || (state_reg == ST_EXPIRED);
    assign tick  = timed && (presc_reg == PRESC_LAST);

    // Modulo-3600 add: the largest sum is 3599 + 61, so one subtract suffices.
    always_comb begin
        sum_raw   = {1'b0, value_reg}
                  + (min_plus ? 13'd60 : 13'd0)
                  + (sec_plus ? 13'd1  : 13'd0);
        value_add = (sum_raw >= 13'd3600) ? 12'(sum_raw - 13'd3600) : sum_raw[11:0];
        value_dec = (value_reg != 12'd0) ? value_reg - 12'd1 : 12'd0;
    end

    always_comb begin
        state_next     = state_reg;
        value_next     = value_reg;
        presc_next     = '0;
        alarm_next     = alarm_reg;
        alarm_cnt_next = alarm_cnt_reg;

        if (!mode) begin
            state_next     = ST_SET;
            alarm_next     = 1'b0;
            alarm_cnt_next = '0;
            if (state_reg != ST_SET) begin
                value_next = 12'd0;
            end else begin
                value_next = value_add;
            end
        end else begin
            case (state_reg)
                ST_SET: begin
                    state_next = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_pause && (value_reg != 12'd0)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A tick wins the decrement even when start_pause coincides.
                    if (tick) begin
                        value_next = value_dec;
                        if (value_dec == 12'd0) begin
                            state_next     = ST_EXPIRED;
                            alarm_next     = 1'b1;
                            alarm_cnt_next = '0;
                        end else if (start_pause) begin
                            state_next = ST_PAUSE;
                        end
                    end else if (start_pause) begin
                        state_next = ST_PAUSE;
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                default: begin
                    if (start_pause) begin
                        state_next     = ST_PAUSE;
                        alarm_next     = 1'b0;
                        alarm_cnt_next = '0;
                    end else begin
                        presc_next = tick ? '0 : presc_reg + PW'(1);
                        if (tick && alarm_reg) begin
                            if (alarm_cnt_reg == ALARM_LAST) begin
                                alarm_next = 1'b0;
                            end else begin
                                alarm_cnt_next = alarm_cnt_reg + AW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_SET;
            value_reg     <= 12'd0;
            presc_reg     <= '0;
            alarm_cnt_reg <= '0;
            alarm_reg     <= 1'b0;
            running_reg   <= 1'b0;
            stop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            value_reg     <= value_next;
            presc_reg     <= presc_next;
            alarm_cnt_reg <= alarm_cnt_next;
            alarm_reg     <= alarm_next;
            running_reg   <= (state_next == ST_RUN);
            stop_reg      <= (state_next == ST_EXPIRED);
        end
    end

    assign value   = value_reg;
    assign running = running_reg;
    assign stop    = stop_reg;
    assign alarm   = alarm_reg;

    // Minutes tens = value/600 because minutes never exceed 59.
    assign bcd[15:12] = 4'(value_reg / 12'd600);
    assign bcd[11:8]  = 4'((value_reg / 12'd60) % 12'd10);
    assign bcd[7:4]   = 4'((value_reg % 12'd60) / 12'd10);
    assign bcd[3:0]   = 4'(value_reg % 12'd10);

endmodule
